// File: rtl/stream_demux_pkg.sv
// -----------------------------------------------------------------------------
// stream_demux_pkg
// Shared types and constants for the stream_demux block.
//   demux_state_t : packet-tracking state of the demultiplexer
//   CNT_W         : width of each per-output packet counter (optional feature)
// -----------------------------------------------------------------------------
package stream_demux_pkg;

   typedef enum logic [1:0] {
      S_IDLE,   // waiting for the first beat of a packet
      S_PKT,    // mid-packet, routing to the locked destination
      S_DROP    // mid-packet with an invalid destination, discarding beats
   } demux_state_t;

   localparam int CNT_W = 16;

endpackage

// File: rtl/stream_reg_slice.sv
// -----------------------------------------------------------------------------
// stream_reg_slice
// Single-entry valid/ready hold register carrying {data, last, dest}.
// A beat can be loaded in the same cycle the held beat drains, so a
// continuously-ready consumer sees one beat per cycle.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid / in_ready     upstream handshake
//   in_data, in_last        upstream payload and end-of-packet flag
//   in_dest                 sideband destination stored with the beat
//   out_full                entry holds a beat
//   out_ready               the consumer selected by out_dest accepts it
//   out_data, out_last      held payload and end-of-packet flag
//   out_dest                held destination
// -----------------------------------------------------------------------------
module stream_reg_slice
   import stream_demux_pkg::*;
#(
   parameter int W  = 8,
   parameter int DW = 1
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   input  logic          in_last,
   input  logic [DW-1:0] in_dest,
   output logic          out_full,
   input  logic          out_ready,
   output logic [W-1:0]  out_data,
   output logic          out_last,
   output logic [DW-1:0] out_dest
);

   logic          r_full;
   logic [W-1:0]  r_data;
   logic          r_last;
   logic [DW-1:0] r_dest;

   // Space is available when empty or when the held beat leaves this cycle.
   assign in_ready = !r_full | out_ready;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   // NOTE: the payload registers are reset as well, so out_data/out_last read
   // zero after reset instead of stale contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_full <= 1'b0;
         r_data <= '0;
         r_last <= 1'b0;
         r_dest <= '0;
      end else if (in_valid & in_ready) begin
         // Load wins over drain: a simultaneous drain is replaced, not lost.
         r_full <= 1'b1;
         r_data <= in_data;
         r_last <= in_last;
         r_dest <= in_dest;
      end else if (out_ready) begin
         r_full <= 1'b0;
      end
   end

   assign out_full = r_full;
   assign out_data = r_data;
   assign out_last = r_last;
   assign out_dest = r_dest;

endmodule

// File: rtl/stream_demux.sv
// -----------------------------------------------------------------------------
// stream_demux
// 1-to-N_OUT packet demultiplexer for valid/ready streams. The destination is
// sampled from in_sel on the first beat of a packet and locked for the rest of
// it. Beats pass through one registered hold stage (1-cycle latency, full
// throughput). Packets whose first-beat in_sel >= N_OUT are consumed and
// discarded, with a one-cycle err_sel pulse.
//
// Parameters: N_OUT (2..16) outputs, W data width; SEL_W is derived.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_valid/in_ready              input handshake
//   in_data, in_last, in_sel       input payload, end-of-packet, destination
//   out_valid[N_OUT]/out_ready     per-output handshake (out_valid one-hot)
//   out_data, out_last             shared payload bus and end-of-packet flag
//   err_sel                        pulse when a packet targets a missing output
//   pkt_count[N_OUT*16]            per-output completed-packet counters,
//                                  present only with STREAM_DEMUX_COUNT_EN
// -----------------------------------------------------------------------------
module stream_demux
   import stream_demux_pkg::*;
#(
   parameter  int N_OUT = 2,
   parameter  int W     = 8,
   localparam int SEL_W = $clog2(N_OUT)
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [W-1:0]       in_data,
   input  logic               in_last,
   input  logic [SEL_W-1:0]   in_sel,
   output logic [N_OUT-1:0]   out_valid,
   input  logic [N_OUT-1:0]   out_ready,
   output logic [W-1:0]       out_data,
   output logic               out_last,
   output logic               err_sel
`ifdef STREAM_DEMUX_COUNT_EN
   ,output logic [N_OUT*CNT_W-1:0] pkt_count
`endif
);

   demux_state_t     r_state;
   demux_state_t     w_state_nxt;
   logic [SEL_W-1:0] r_dest_lock;
   logic             r_err_sel;

   logic             w_sel_bad;
   logic             w_drop;
   logic             w_in_xfer;
   logic             w_first;
   logic [SEL_W-1:0] w_dest;
   logic             w_slice_valid;
   logic             w_slice_ready;
   logic             w_full;
   logic             w_drain;
   logic [SEL_W-1:0] w_out_dest;

   // One extra bit so N_OUT itself is representable when it is a power of two.
   assign w_sel_bad = ({1'b0, in_sel} >= (SEL_W+1)'(N_OUT));
   assign w_first   = (r_state == S_IDLE);

   // Beats of a bad-destination packet are swallowed regardless of the hold
   // register, so a stalled consumer never blocks discarding.
   assign w_drop        = (r_state == S_DROP) | (w_first & w_sel_bad);
   assign w_dest        = w_first ? in_sel : r_dest_lock;
   assign w_slice_valid = in_valid & !w_drop;
   assign in_ready      = w_drop | w_slice_ready;
   assign w_in_xfer     = in_valid & in_ready;

   stream_reg_slice #(
      .W  (W),
      .DW (SEL_W)
   ) u_slice (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (w_slice_valid),
      .in_ready  (w_slice_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_dest   (w_dest),
      .out_full  (w_full),
      .out_ready (w_drain),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_dest  (w_out_dest)
   );

   // Decode depends only on registered state, never on out_ready.
   always_comb begin
      // NOTE: every bit gets a default first so no latch is inferred.
      out_valid = '0;
      for (int k = 0; k < N_OUT; k++) begin
         out_valid[k] = w_full & (w_out_dest == SEL_W'(k));
      end
   end

   // Only the targeted consumer's ready can free the hold register.
   assign w_drain = |(out_valid & out_ready);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_in_xfer & !in_last) begin
               w_state_nxt = w_sel_bad ? S_DROP : S_PKT;
            end
         end
         S_PKT, S_DROP: begin
            if (w_in_xfer & in_last) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_dest_lock <= '0;
         r_err_sel   <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_err_sel <= w_first & w_in_xfer & w_sel_bad;
         if (w_first & w_in_xfer) begin
            r_dest_lock <= in_sel;
         end
      end
   end

   assign err_sel = r_err_sel;

`ifdef STREAM_DEMUX_COUNT_EN
   logic [N_OUT-1:0][CNT_W-1:0] r_pkt_count;

   // Counts completed packets per output; wraps naturally at 2^CNT_W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pkt_count <= '0;
      end else begin
         for (int k = 0; k < N_OUT; k++) begin
            if (out_valid[k] & out_ready[k] & out_last) begin
               r_pkt_count[k] <= r_pkt_count[k] + CNT_W'(1);
            end
         end
      end
   end

   assign pkt_count = r_pkt_count;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// -----------------------------------------------------------------------------
// tb_stream_demux
// Two instances share one input stream: u_dut4 (N_OUT=4) and u_dut3 (N_OUT=3),
// so sel=3 is a legal route on one and a dropped packet on the other. The
// driver pushes the expected {dest, data, last} per instance into a queue as
// each beat is accepted; a negedge monitor pops and compares on every output
// transfer. Define STREAM_DEMUX_COUNT_EN to also check pkt_count.
// -----------------------------------------------------------------------------
module tb_stream_demux;

   typedef struct {
      int         dest;
      logic [7:0] data;
      logic       last;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_last;
   logic [1:0] in_sel;
   logic [3:0] out_ready;

   logic       in_ready4, out_last4, err4;
   logic [3:0] out_valid4;
   logic [7:0] out_data4;
   logic       in_ready3, out_last3, err3;
   logic [2:0] out_valid3;
   logic [7:0] out_data3;
`ifdef STREAM_DEMUX_COUNT_EN
   logic [63:0] pkt_count4;
   logic [47:0] pkt_count3;
`endif

   exp_t q4[$];
   exp_t q3[$];
   int   n_vec  = 0;
   int   n_miss = 0;
   int   err4_cnt = 0;
   int   err3_cnt = 0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   stream_demux #(.N_OUT(4), .W(8)) u_dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready4),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_sel    (in_sel),
      .out_valid (out_valid4),
      .out_ready (out_ready),
      .out_data  (out_data4),
      .out_last  (out_last4),
      .err_sel   (err4)
`ifdef STREAM_DEMUX_COUNT_EN
      ,.pkt_count (pkt_count4)
`endif
   );

   stream_demux #(.N_OUT(3), .W(8)) u_dut3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready3),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_sel    (in_sel),
      .out_valid (out_valid3),
      .out_ready (out_ready[2:0]),
      .out_data  (out_data3),
      .out_last  (out_last3),
      .err_sel   (err3)
`ifdef STREAM_DEMUX_COUNT_EN
      ,.pkt_count (pkt_count3)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (err4) err4_cnt++;
         if (err3) err3_cnt++;
         if (out_valid4 != 0) check("dut4 onehot", 64'($countones(out_valid4)), 64'd1);
         if (out_valid3 != 0) check("dut3 onehot", 64'($countones(out_valid3)), 64'd1);
         for (int k = 0; k < 4; k++) begin
            if (out_valid4[k] && out_ready[k]) begin
               if (q4.size() == 0) begin
                  check("dut4 unexpected beat", {48'(k), out_data4, 7'd0, out_last4}, 64'hFFFF);
               end else begin
                  e = q4.pop_front();
                  check("dut4 beat", {48'(k), out_data4, 7'd0, out_last4},
                        {48'(e.dest), e.data, 7'd0, e.last});
               end
            end
         end
         for (int k = 0; k < 3; k++) begin
            if (out_valid3[k] && out_ready[k]) begin
               if (q3.size() == 0) begin
                  check("dut3 unexpected beat", {48'(k), out_data3, 7'd0, out_last3}, 64'hFFFF);
               end else begin
                  e = q3.pop_front();
                  check("dut3 beat", {48'(k), out_data3, 7'd0, out_last3},
                        {48'(e.dest), e.data, 7'd0, e.last});
               end
            end
         end
      end
   end

   // ---------------- driver ----------------
   // Presents one beat and returns 1 ns after the edge that accepted it, with
   // in_valid still high so back-to-back calls run at one beat per cycle.
   // exp4/exp3 give the expected output index per instance (-1 = dropped).
   task automatic send_beat(input logic [1:0] sel, input logic [7:0] d, input logic l,
                            input int exp4, input int exp3);
      int guard = 0;
      bit ok    = 0;
      in_valid = 1'b1;
      in_sel   = sel;
      in_data  = d;
      in_last  = l;
      while (!ok && guard < 50) begin
         @(negedge clk);
         ok = in_ready4 && in_ready3;
         if (ok) begin
            if (exp4 >= 0) q4.push_back('{dest: exp4, data: d, last: l});
            if (exp3 >= 0) q3.push_back('{dest: exp3, data: d, last: l});
         end
         @(posedge clk);
         #1;
         guard++;
      end
      if (!ok) check("in_ready timeout", 64'(guard), 64'd0);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      int e3_base;

      // 1. Reset with random inputs
      rst_n     = 1'b0;
      out_ready = 4'hF;
      repeat (4) begin
         in_valid  = 1'($urandom);
         in_data   = 8'($urandom);
         in_last   = 1'($urandom);
         in_sel    = 2'($urandom);
         out_ready = 4'($urandom);
         @(negedge clk);
         check("reset out_valid4", 64'(out_valid4), 64'd0);
         check("reset out_valid3", 64'(out_valid3), 64'd0);
         check("reset err_sel", {62'd0, err4, err3}, 64'd0);
         check("reset out_data/last", {55'd0, out_data4, out_last4}, 64'd0);
      end
`ifdef STREAM_DEMUX_COUNT_EN
      check("reset pkt_count4", pkt_count4, 64'd0);
`endif
      in_valid  = 1'b0;
      out_ready = 4'hF;
      rst_n     = 1'b1;
      @(posedge clk);
      #1;
      check("in_ready after reset", {62'd0, in_ready4, in_ready3}, 64'd3);

      // 2. Routing: 3-beat packet to output 2
      send_beat(2'd2, 8'h11, 1'b0, 2, 2);
      check("latency out_valid4", 64'(out_valid4), 64'h4);
      check("latency out_valid3", 64'(out_valid3), 64'h4);
      send_beat(2'd2, 8'h22, 1'b0, 2, 2);
      send_beat(2'd2, 8'h33, 1'b1, 2, 2);
      idle(2);

      // 3. Select lock: in_sel changes mid-packet, beats stay on output 1
      send_beat(2'd1, 8'hA1, 1'b0, 1, 1);
      send_beat(2'd0, 8'hA2, 1'b0, 1, 1);
      send_beat(2'd0, 8'hA3, 1'b1, 1, 1);
      idle(2);

      // 4. Backpressure on output 1
      out_ready = 4'b1101;
      send_beat(2'd1, 8'hB1, 1'b0, 1, 1);
      in_valid = 1'b1;
      in_data  = 8'hB2;
      repeat (5) begin
         @(negedge clk);
         check("stall in_ready4", 64'(in_ready4), 64'd0);
         check("stall hold4", {52'd0, out_valid4, out_data4}, {52'd0, 4'b0010, 8'hB1});
      end
      @(posedge clk);
      #1;
      out_ready = 4'hF;
      t0 = cyc;
      send_beat(2'd1, 8'hB2, 1'b0, 1, 1);
      send_beat(2'd1, 8'hB3, 1'b1, 1, 1);
      check("throughput cycles", 64'(cyc - t0), 64'd2);
      idle(2);

      // 5. Bad select on the N_OUT=3 instance (legal on N_OUT=4)
      e3_base = err3_cnt;
      send_beat(2'd3, 8'hC1, 1'b0, 3, -1);
      send_beat(2'd3, 8'hC2, 1'b1, 3, -1);
      idle(2);
      check("err_sel pulse 2-beat", 64'(err3_cnt - e3_base), 64'd1);
      send_beat(2'd0, 8'hD0, 1'b1, 0, 0);
      send_beat(2'd3, 8'hE0, 1'b1, 3, -1);
      send_beat(2'd0, 8'hE1, 1'b1, 0, 0);
      idle(2);
      check("err_sel pulses total", 64'(err3_cnt - e3_base), 64'd2);
      check("err_sel dut4 none", 64'(err4_cnt), 64'd0);

      // 6. Reset mid-packet
      send_beat(2'd1, 8'hF1, 1'b0, 1, 1);
      send_beat(2'd1, 8'hF2, 1'b0, 1, 1);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      check("mid-reset out_valid4", 64'(out_valid4), 64'd0);
      check("mid-reset out_valid3", 64'(out_valid3), 64'd0);
      q4.delete();
      q3.delete();
`ifdef STREAM_DEMUX_COUNT_EN
      check("mid-reset pkt_count4", pkt_count4, 64'd0);
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send_beat(2'd1, 8'h71, 1'b0, 1, 1);
      send_beat(2'd0, 8'h72, 1'b1, 1, 1);
      idle(3);
`ifdef STREAM_DEMUX_COUNT_EN
      check("pkt_count4", pkt_count4, 64'h0000_0000_0001_0000);
      check("pkt_count3", {16'd0, pkt_count3}, 64'h0000_0000_0001_0000);
`endif

      check("q4 drained", 64'(q4.size()), 64'd0);
      check("q3 drained", 64'(q3.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
